// File: rtl/fp_mul_arb_pkg.sv
// Shared definitions for the round-robin arbiter that fronts one single-precision multiplier.
package fp_mul_arb_pkg;

  localparam int NREQ_MAX = 8;
  localparam int OPCNT_W  = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT_Z  = 3'd3,
    S_RETURN  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last+1 with wrap-around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            valid,
  output logic [IDW-1:0]  win
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    valid = 1'b0;
    win   = '0;
    w_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((int'(last) + k) % NREQ);
      if (!valid && req[w_idx]) begin
        valid = 1'b1;
        win   = w_idx;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one multiplier among NREQ requesters; operands and products pass through untouched.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  input  logic [NREQ-1:0]        req_stb,
  output logic [NREQ-1:0]        req_ack,
  output logic [WORD_W-1:0]      rsp_z,
  output logic [NREQ-1:0]        rsp_stb,
  input  logic [NREQ-1:0]        rsp_ack,
  output logic [WORD_W-1:0]      mul_a,
  output logic [WORD_W-1:0]      mul_b,
  output logic                   mul_a_stb,
  output logic                   mul_b_stb,
  input  logic                   mul_a_ack,
  input  logic                   mul_b_ack,
  input  logic [WORD_W-1:0]      mul_z,
  input  logic                   mul_z_stb,
  output logic                   mul_z_ack,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic [OPCNT_W-1:0]     op_count
);

  state_t              r_state, w_state_nxt;
  logic [NREQ-1:0]     r_req_ack, w_req_ack_nxt;
  logic [NREQ-1:0]     r_rsp_stb, w_rsp_stb_nxt;
  logic [IDW-1:0]      r_grant, w_grant_nxt;
  logic [IDW-1:0]      r_last, w_last_nxt;
  logic [WORD_W-1:0]   r_mul_a, w_mul_a_nxt;
  logic [WORD_W-1:0]   r_mul_b, w_mul_b_nxt;
  logic                r_mul_stb, w_mul_stb_nxt;
  logic                r_zack, w_zack_nxt;
  logic [WORD_W-1:0]   r_rsp_z, w_rsp_z_nxt;
  logic [OPCNT_W-1:0]  r_op_count, w_cnt_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_rr_valid;
  logic [IDW-1:0]      w_rr_win;
  logic [WORD_W-1:0]   w_sel_a, w_sel_b;
  logic                w_sel_stb, w_sel_rack;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req   (req_stb),
    .last  (r_last),
    .valid (w_rr_valid),
    .win   (w_rr_win)
  );

  // Inputs belonging to the currently granted requester.
  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_stb  = 1'b0;
    w_sel_rack = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_sel_a    = req_a[i*WORD_W +: WORD_W];
        w_sel_b    = req_b[i*WORD_W +: WORD_W];
        w_sel_stb  = req_stb[i];
        w_sel_rack = rsp_ack[i];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_ack_nxt = r_req_ack;
    w_rsp_stb_nxt = r_rsp_stb;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_mul_a_nxt   = r_mul_a;
    w_mul_b_nxt   = r_mul_b;
    w_mul_stb_nxt = r_mul_stb;
    w_zack_nxt    = r_zack;
    w_rsp_z_nxt   = r_rsp_z;
    w_cnt_nxt     = r_op_count;
    case (r_state)
      S_IDLE: begin
        if (w_rr_valid) begin
          w_grant_nxt   = w_rr_win;
          w_req_ack_nxt = NREQ'(1) << w_rr_win;
          w_state_nxt   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // A requester that withdrew before its ack is dropped without touching the pointer.
        w_req_ack_nxt = '0;
        if (w_sel_stb) begin
          w_mul_a_nxt   = w_sel_a;
          w_mul_b_nxt   = w_sel_b;
          w_mul_stb_nxt = 1'b1;
          w_state_nxt   = S_ISSUE;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_mul_stb && mul_a_ack && mul_b_ack) begin
          w_mul_stb_nxt = 1'b0;
          w_zack_nxt    = 1'b1;
          w_state_nxt   = S_WAIT_Z;
        end
      end
      S_WAIT_Z: begin
        if (mul_z_stb && r_zack) begin
          w_rsp_z_nxt   = mul_z;
          w_zack_nxt    = 1'b0;
          w_rsp_stb_nxt = NREQ'(1) << r_grant;
          w_state_nxt   = S_RETURN;
        end
      end
      S_RETURN: begin
        if (w_sel_rack) begin
          w_rsp_stb_nxt = '0;
          w_last_nxt    = r_grant;
          w_cnt_nxt     = r_op_count + 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req_ack  <= '0;
      r_rsp_stb  <= '0;
      r_grant    <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_stb  <= 1'b0;
      r_zack     <= 1'b0;
      r_rsp_z    <= '0;
      r_op_count <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_ack  <= w_req_ack_nxt;
      r_rsp_stb  <= w_rsp_stb_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_mul_a    <= w_mul_a_nxt;
      r_mul_b    <= w_mul_b_nxt;
      r_mul_stb  <= w_mul_stb_nxt;
      r_zack     <= w_zack_nxt;
      r_rsp_z    <= w_rsp_z_nxt;
      r_op_count <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign req_ack   = r_req_ack;
  assign rsp_stb   = r_rsp_stb;
  assign rsp_z     = r_rsp_z;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_a_stb = r_mul_stb;
  assign mul_b_stb = r_mul_stb;
  assign mul_z_ack = r_zack;
  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench: requesters, a behavioural multiplier and a response monitor run in one env process.
module tb_fp_mul_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ*32-1:0]   req_a = '0;
  logic [NREQ*32-1:0]   req_b = '0;
  logic [NREQ-1:0]      req_stb = '0;
  logic [NREQ-1:0]      req_ack;
  logic [31:0]          rsp_z;
  logic [NREQ-1:0]      rsp_stb;
  logic [NREQ-1:0]      rsp_ack = '1;
  logic [31:0]          mul_a, mul_b;
  logic                 mul_a_stb, mul_b_stb;
  logic                 mul_a_ack = 1'b0;
  logic                 mul_b_ack = 1'b0;
  logic [31:0]          mul_z = '0;
  logic                 mul_z_stb = 1'b0;
  logic                 mul_z_ack;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic [15:0]          op_count;

  fp_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
    .rsp_z(rsp_z), .rsp_stb(rsp_stb), .rsp_ack(rsp_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .busy(busy), .grant_id(grant_id), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] z;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  int          grant_log[$];

  // Controls written by tests, read by env.
  int          want[NREQ] = '{default: 0};
  logic [NREQ-1:0] rsp_hold = '0;
  logic [NREQ-1:0] use_fixed = '0;
  logic [31:0] fixed_a[NREQ] = '{default: 32'h0};
  logic [31:0] fixed_b[NREQ] = '{default: 32'h0};
  int          ack_mode = 0;
  int          mul_lat = 0;

  // Env state.
  int          issued[NREQ] = '{default: 0};
  logic [31:0] cur_a[NREQ] = '{default: 32'h0};
  logic [31:0] cur_b[NREQ] = '{default: 32'h0};
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_z = '0;

  // Truncating multiply of normal single-precision values.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      f = m[46:24];
      e = e + 10'd1;
    end else begin
      f = m[45:23];
    end
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  always begin : env
    logic [NREQ-1:0] s_req_x, s_rsp_x, need_new;
    logic            s_mul_x, s_z_x;
    exp_t            e;
    @(negedge clk);
    s_req_x = req_stb & req_ack;
    s_rsp_x = rsp_stb & rsp_ack;
    s_mul_x = mul_a_stb & mul_b_stb & mul_a_ack & mul_b_ack;
    s_z_x   = mul_z_stb & mul_z_ack;
    if (|req_ack) begin
      grant_log.push_back(int'(grant_id));
      checks++;
      if (req_ack !== (NREQ'(1) << grant_id)) begin
        errors++;
        $display("FAIL req_ack_onehot got %b want %b", req_ack, NREQ'(1) << grant_id);
      end
    end
    if (|s_rsp_x) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got rsp_stb=%b z=%h want no response", rsp_stb, rsp_z);
      end else begin
        e = sb_q.pop_front();
        if (rsp_stb !== (NREQ'(1) << e.id) || rsp_z !== e.z) begin
          errors++;
          $display("FAIL rsp_data got stb=%b z=%h want stb=%b z=%h",
                   rsp_stb, rsp_z, NREQ'(1) << e.id, e.z);
        end
      end
    end
    @(posedge clk);
    #1;
    need_new = ~req_stb | s_req_x;
    if (!rst) begin
      sb_q.delete();
      for (int i = 0; i < NREQ; i++) issued[i] = want[i];
      m_pend    = 1'b0;
      mul_z_stb = 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (s_req_x[i]) begin
          e.id = i;
          e.z  = fmul(cur_a[i], cur_b[i]);
          sb_q.push_back(e);
          issued[i]++;
        end
      end
      if (s_mul_x) begin
        m_pend = 1'b1;
        m_cnt  = mul_lat;
        m_z    = fmul(mul_a, mul_b);
      end
      if (s_z_x) begin
        mul_z_stb = 1'b0;
        m_pend    = 1'b0;
      end else if (m_pend && !mul_z_stb) begin
        if (m_cnt == 0) begin
          mul_z_stb = 1'b1;
          mul_z     = m_z;
        end else begin
          m_cnt--;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rst && issued[i] < want[i]) begin
        if (need_new[i]) begin
          cur_a[i] = use_fixed[i] ? fixed_a[i] : rand_op();
          cur_b[i] = use_fixed[i] ? fixed_b[i] : rand_op();
        end
        req_stb[i] = 1'b1;
      end else begin
        req_stb[i] = 1'b0;
      end
      req_a[i*32 +: 32] = cur_a[i];
      req_b[i*32 +: 32] = cur_b[i];
    end
    rsp_ack = ~rsp_hold;
    case (ack_mode)
      1: begin
        mul_a_ack = mul_a_stb & 1'($urandom_range(0, 1));
        mul_b_ack = mul_b_stb & 1'($urandom_range(0, 1));
      end
      2: begin
        mul_a_ack = mul_a_stb;
        mul_b_ack = 1'b0;
      end
      default: begin
        mul_a_ack = mul_a_stb;
        mul_b_ack = mul_b_stb;
      end
    endcase
    if (!rst) begin
      mul_a_ack = 1'b0;
      mul_b_ack = 1'b0;
    end
  end

  function automatic logic quiet();
    logic q;
    q = !busy && (req_stb == '0) && (sb_q.size() == 0);
    for (int i = 0; i < NREQ; i++) if (issued[i] != want[i]) q = 1'b0;
    return q;
  endfunction

  task automatic wait_quiet(output logic ok);
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      if (quiet()) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got req_ack=%b rsp_stb=%b stb=%b%b zack=%b busy=%b want all 0",
               req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy);
    end
    checks++;
    if ({rsp_z, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL reset_data got z=%h a=%h b=%h want 0", rsp_z, mul_a, mul_b);
    end
    checks++;
    if (grant_id !== '0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got grant=%0d op_count=%0d want 0 0", grant_id, op_count);
    end
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic ok;
    int   base;
    base = grant_log.size();
    use_fixed[2] = 1'b1;
    fixed_a[2] = 32'h4000_0000;
    fixed_b[2] = 32'h4040_0000;
    want[2]++;
    wait_quiet(ok);
    use_fixed[2] = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got busy=%b want idle", busy); end
    checks++;
    if (rsp_z !== 32'h40C0_0000) begin
      errors++; $display("FAIL single_z got %h want 40c00000", rsp_z);
    end
    checks++;
    if (op_count !== 16'd1) begin
      errors++; $display("FAIL single_count got %0d want 1", op_count);
    end
    checks++;
    if (grant_log.size() != base + 1 || grant_id !== 2'd2) begin
      errors++; $display("FAIL single_grant got n=%0d id=%0d want n=1 id=2", grant_log.size() - base, grant_id);
    end
  endtask

  task automatic test_rr_all();
    logic ok;
    int   base;
    int   exp_order[8];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    pulse_reset();
    base = grant_log.size();
    ack_mode = 1;
    for (int i = 0; i < NREQ; i++) want[i] += 2;
    wait_quiet(ok);
    ack_mode = 0;
    checks++;
    if (!ok || grant_log.size() != base + 8) begin
      errors++; $display("FAIL rr_all_count got %0d grants want 8", grant_log.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (grant_log[base + k] != exp_order[k]) begin
          errors++; $display("FAIL rr_all_order[%0d] got %0d want %0d", k, grant_log[base + k], exp_order[k]);
        end
      end
    end
    checks++;
    if (op_count !== 16'd8) begin
      errors++; $display("FAIL rr_all_opcount got %0d want 8", op_count);
    end
  endtask

  task automatic test_alternate();
    logic ok;
    int   base;
    base = grant_log.size();
    want[1] += 3;
    want[3] += 3;
    wait_quiet(ok);
    checks++;
    if (!ok || grant_log.size() != base + 6) begin
      errors++; $display("FAIL alt_count got %0d grants want 6", grant_log.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (grant_log[base + k] != ((k % 2 == 0) ? 1 : 3)) begin
          errors++; $display("FAIL alt_order[%0d] got %0d want %0d", k, grant_log[base + k], (k % 2 == 0) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_rsp_hold();
    logic        ok;
    logic [31:0] snap;
    int          base;
    base = grant_log.size();
    rsp_hold[0] = 1'b1;
    want[0]++;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rsp_stb[0]) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout got rsp_stb=%b want 0001", rsp_stb); end
    snap = rsp_z;
    want[1]++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_stb !== 4'b0001 || busy !== 1'b1 || req_ack !== 4'b0000 || rsp_z !== snap) begin
        errors++;
        $display("FAIL hold_cycle%0d got stb=%b busy=%b ack=%b z=%h want 0001 1 0000 %h",
                 c, rsp_stb, busy, req_ack, rsp_z, snap);
      end
    end
    rsp_hold[0] = 1'b0;
    wait_quiet(ok);
    checks++;
    if (!ok || grant_log.size() != base + 2 || grant_log[base] != 0 || grant_log[base + 1] != 1) begin
      errors++; $display("FAIL hold_after got %0d grants want 0 then 1", grant_log.size() - base);
    end
  endtask

  task automatic test_single_ack();
    logic        ok;
    logic [31:0] snap;
    ack_mode = 2;
    want[2]++;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mul_a_stb) begin ok = 1'b1; break; end
    end
    snap = mul_a;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (!ok || mul_a_stb !== 1'b1 || mul_b_stb !== 1'b1 || mul_z_ack !== 1'b0 || mul_a !== snap) begin
        errors++;
        $display("FAIL one_ack got stb=%b%b zack=%b a=%h want 11 0 %h", mul_a_stb, mul_b_stb, mul_z_ack, mul_a, snap);
      end
    end
    ack_mode = 0;
    wait_quiet(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL one_ack_timeout got busy=%b want idle", busy); end
  endtask

  task automatic test_reset_wait_z();
    logic ok;
    int   base;
    mul_lat = 10;
    want[1]++;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mul_z_ack) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rstz_reach got zack=%b want 1", mul_z_ack); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy} !== '0 || op_count !== 16'd0) begin
      errors++;
      $display("FAIL rstz_clear got ack=%b stb=%b mstb=%b%b zack=%b busy=%b cnt=%0d want all 0",
               req_ack, rsp_stb, mul_a_stb, mul_b_stb, mul_z_ack, busy, op_count);
    end
    rst = 1'b1;
    mul_lat = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_stb !== '0) begin
      errors++; $display("FAIL rstz_idle got busy=%b rsp_stb=%b want 0 0000", busy, rsp_stb);
    end
    base = grant_log.size();
    want[2]++;
    wait_quiet(ok);
    checks++;
    if (!ok || op_count !== 16'd1 || grant_log.size() != base + 1 || grant_log[base] != 2) begin
      errors++; $display("FAIL rstz_after got cnt=%0d grants=%0d want 1 1", op_count, grant_log.size() - base);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    @(negedge clk);
    force dut.r_op_count = 16'hFFFE;
    @(negedge clk);
    release dut.r_op_count;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload got %h want fffe", op_count); end
    want[0]++;
    wait_quiet(ok);
    checks++;
    if (!ok || op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", op_count); end
    want[0]++;
    wait_quiet(ok);
    checks++;
    if (!ok || op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_all();
    test_alternate();
    test_rsp_hold();
    test_single_ack();
    test_reset_wait_z();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter IDW, default 2, SHALL set the grant_id width; IDW SHALL equal clog2(NREQ).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_a  input  NREQ*32  operand A per requester; slice i is bits [32i+31:32i].
REQ-006 req_b  input  NREQ*32  operand B per requester, sliced the same way as req_a.
REQ-007 req_stb  input  NREQ  per-requester operand strobe.
REQ-008 req_ack  output  NREQ  per-requester operand acknowledge.
REQ-009 rsp_z  output  32  product returned to the granted requester.
REQ-010 rsp_stb  output  NREQ  per-requester result strobe.
REQ-011 rsp_ack  input  NREQ  per-requester result acknowledge.
REQ-012 mul_a, mul_b  output  32 each  operands to the shared single-precision multiplier.
REQ-013 mul_a_stb, mul_b_stb  output  1 each  operand strobes to the multiplier.
REQ-014 mul_a_ack, mul_b_ack  input  1 each  operand acknowledges from the multiplier.
REQ-015 mul_z  input  32  product from the multiplier.
REQ-016 mul_z_stb  input  1  product strobe from the multiplier.
REQ-017 mul_z_ack  output  1  product acknowledge to the multiplier.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 grant_id  output  IDW  index of the current or last granted requester.
REQ-020 op_count  output  16  count of completed operations; wraps 0xFFFF->0.

Function
REQ-021 A transfer on any stb/ack pair SHALL occur only on a clock edge where both are high.
REQ-022 All outputs SHALL be registered.
REQ-023 The FSM SHALL have exactly five states: IDLE, CAPTURE, ISSUE, WAIT_Z, RETURN.
REQ-024 IDLE: if any req_stb is high, pick winner g by round-robin, set grant_id<=g, set req_ack[g]<=1, go to CAPTURE; otherwise stay in IDLE.
REQ-025 Round-robin: priority SHALL start at (last_grant+1) mod NREQ and search upward with wrap-around; after reset, last_grant SHALL be NREQ-1 so requester 0 wins first.
REQ-026 CAPTURE: latch slice g of req_a/req_b into mul_a/mul_b, clear req_ack, set mul_a_stb=mul_b_stb=1, go to ISSUE.
REQ-027 A requester SHALL hold req_stb and its operands stable until acknowledged; if req_stb[g] is low in CAPTURE, return to IDLE with no issue and no pointer update.
REQ-028 ISSUE: on a transfer with mul_a_ack and mul_b_ack both high, clear both mul strobes, set mul_z_ack=1, go to WAIT_Z.
REQ-029 ISSUE: a single-sided ack SHALL keep both strobes high and wait for the other ack.
REQ-030 WAIT_Z: on mul_z_stb&&mul_z_ack, latch rsp_z<=mul_z, clear mul_z_ack, set rsp_stb[g]=1, go to RETURN.
REQ-031 RETURN: on rsp_stb[g]&&rsp_ack[g], clear rsp_stb, set last_grant<=g, increment op_count, go to IDLE.
REQ-032 RETURN SHALL wait indefinitely on a low rsp_ack[g], with no new grant.
REQ-033 At most one bit of req_ack, and at most one bit of rsp_stb, SHALL be high at any time.
REQ-034 Arbiter overhead SHALL be 4 cycles beyond multiplier latency and the two handshakes.
REQ-035 Requests arriving in states other than IDLE SHALL wait; none SHALL be dropped.
REQ-036 Operand and result values SHALL pass through unmodified; no FP interpretation.

Reset
REQ-037 On rst low: state=IDLE, req_ack=0, rsp_stb=0, mul_a_stb=mul_b_stb=0, mul_z_ack=0, rsp_z=0, mul_a=mul_b=0, grant_id=0, last_grant=NREQ-1, op_count=0, busy=0.
REQ-038 Reset mid-operation SHALL abandon the operation with no response; the multiplier SHALL share the same rst.

Structure
REQ-039 Package fp_mul_arb_pkg SHALL hold the state encoding, NREQ_MAX=8 and the op_count width.
REQ-040 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: valid, winner index).

Verification
REQ-041 Requester 2 sends 0x40000000 x 0x40400000 -> rsp_stb[2] with rsp_z=0x40C00000; op_count=1.
REQ-042 All four req_stb high from reset, held -> grant order 0,1,2,3,0; each rsp_z matches its own operands.
REQ-043 Requesters 1 and 3 permanently requesting -> grants alternate 1,3,1,3; requester 0 is never acked.
REQ-044 rsp_ack[0] held low 10 cycles in RETURN -> rsp_stb[0] stays high, busy=1, no req_ack asserted, rsp_z stable.
REQ-045 rst low during WAIT_Z -> next cycle all strobes/acks 0 and state IDLE; a new request then completes normally.
REQ-046 op_count preloaded near 0xFFFF by running 65536 ops (or forced) -> wraps to 0x0000.
